waveform_buffer: RTL and testbench

WAVEFORM_BUFFER -- requirements
Module: waveform_buffer

---
 rtl/waveform_buffer_pkg.sv | 25 ++
 rtl/waveform_ram.sv | 28 ++
 rtl/waveform_buffer.sv | 154 +++++++++++++++
 tb/tb_waveform_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_buffer_pkg.sv
// Shared definitions for the waveform capture and display path:
// system status codes, buffer FSM states and default geometry.
package waveform_buffer_pkg;

  localparam int WB_ADDR_WIDTH = 10;
  localparam int WB_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    STATUS_PAUSED  = 3'd0,
    STATUS_RUNNING = 3'd1,
    STATUS_ERROR   = 3'd2,
    STATUS_BOOT    = 3'd3
  } sys_status_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } wb_state_e;

  function automatic logic is_running(input logic [2:0] status);
    return status == STATUS_RUNNING;
  endfunction

endpackage

// File: rtl/waveform_ram.sv
// Simple dual-port sample store: one write port and one registered,
// read-first read port, written so synthesis maps it onto block RAM.
module waveform_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/waveform_buffer.sv
// Circular, decimating waveform capture buffer read back by column for display.
// state | meaning: CLEAR zero every entry | RUN accept and average samples | HOLD frozen trace
import waveform_buffer_pkg::*;

module waveform_buffer #(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                  clk_65mhz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [2:0]            system_status,
  input  logic [10:0]           signal_pix,
  output logic [DATA_WIDTH-1:0] signal_out,
  output logic                  ready,
  output logic                  buffer_full,
  output logic [ADDR_WIDTH-1:0] write_ptr
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int ACC_W = DATA_WIDTH + DECIM_LOG2;
  localparam int DEC_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DEC_W-1:0]      LAST_DEC  = DEC_W'((2**DECIM_LOG2) - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DEC_W-1:0]      dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  out_zero_q, out_zero_d;

  logic                  running;
  logic                  accept;
  logic                  dec_last;
  logic                  pix_oob;
  logic [ACC_W-1:0]      sum;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    running  = is_running(system_status);
    accept   = (state_q == ST_RUN) && running && sample_valid;
    dec_last = (dec_cnt_q == LAST_DEC);
    sum      = acc_q + ACC_W'(sample_in);
    pix_oob  = (32'(signal_pix) >= 32'(DEPTH));
    // Offsetting by write_ptr puts the oldest sample in column 0.
    rd_addr  = wr_ptr_q + signal_pix[ADDR_WIDTH-1:0];
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q;
    ram_wdata = '0;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
      end else if (accept && dec_last) begin
        ram_we    = 1'b1;
        ram_wdata = DATA_WIDTH'(sum >> DECIM_LOG2);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    acc_d      = acc_q;
    dec_cnt_d  = dec_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    out_zero_d = pix_oob || (state_q == ST_CLEAR);
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = running ? ST_RUN : ST_HOLD;
        end
      end
      ST_RUN: begin
        if (!running) begin
          state_d   = ST_HOLD;
          acc_d     = '0;
          dec_cnt_d = '0;
        end else if (accept) begin
          if (dec_last) begin
            wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
            acc_d     = '0;
            dec_cnt_d = '0;
            if (wr_cnt_q != FULL_CNT) begin
              wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
          end else begin
            acc_d     = sum;
            dec_cnt_d = dec_cnt_q + DEC_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (running) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_65mhz) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      acc_q      <= '0;
      dec_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      out_zero_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      acc_q      <= acc_d;
      dec_cnt_q  <= dec_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      out_zero_q <= out_zero_d;
    end
  end

  waveform_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk     (clk_65mhz),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  assign signal_out  = out_zero_q ? '0 : ram_rdata;
  assign ready       = (state_q != ST_CLEAR);
  assign buffer_full = (wr_cnt_q == FULL_CNT);
  assign write_ptr   = wr_ptr_q;

endmodule

// File: tb/tb_waveform_buffer.sv
// Bench for waveform_buffer: array/arithmetic model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_waveform_buffer;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DL    = 2;
  localparam int DEPTH = 1024;
  localparam int NDEC  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic [2:0]    system_status = 3'd1;
  logic [10:0]   signal_pix = '0;
  logic [DW-1:0] signal_out;
  logic          ready;
  logic          buffer_full;
  logic [AW-1:0] write_ptr;

  always #5 clk = ~clk;

  waveform_buffer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DECIM_LOG2(DL)
  ) dut (
    .clk_65mhz     (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .system_status (system_status),
    .signal_pix    (signal_pix),
    .signal_out    (signal_out),
    .ready         (ready),
    .buffer_full   (buffer_full),
    .write_ptr     (write_ptr)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: memory as a plain array, states as two flags, averaging by division.
  int mem_m [DEPTH];
  bit live_m = 0;
  bit clearing_m;
  bit run_m;
  int clr_m, wp_m, acc_m, n_m, cnt_m, out_m;

  always @(posedge clk) begin
    if (reset) begin
      live_m = 1; clearing_m = 1; run_m = 0;
      clr_m = 0; wp_m = 0; acc_m = 0; n_m = 0; cnt_m = 0; out_m = 0;
    end else if (live_m) begin
      out_m = (signal_pix >= DEPTH || clearing_m) ? 0 : mem_m[(wp_m + signal_pix) % DEPTH];
      if (clearing_m) begin
        mem_m[clr_m] = 0;
        if (clr_m == DEPTH - 1) begin
          clearing_m = 0;
          run_m = (system_status == 3'd1);
        end
        clr_m++;
      end else if (run_m) begin
        if (system_status != 3'd1) begin
          run_m = 0; acc_m = 0; n_m = 0;
        end else if (sample_valid) begin
          acc_m += sample_in;
          n_m++;
          if (n_m == NDEC) begin
            mem_m[wp_m] = acc_m / NDEC;
            wp_m = (wp_m + 1) % DEPTH;
            acc_m = 0; n_m = 0;
            if (cnt_m < DEPTH) cnt_m++;
          end
        end
      end else if (system_status == 3'd1) begin
        run_m = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (live_m) begin
      chk("ready", int'(ready), int'(!clearing_m));
      chk("buffer_full", int'(buffer_full), int'(cnt_m == DEPTH));
      chk("write_ptr", int'(write_ptr), wp_m);
      chk("signal_out", int'(signal_out), out_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic feed(input int v);
    sample_in = DW'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic read_col(input int c, output int v);
    signal_pix = 11'(c);
    tick();
    v = int'(signal_out);
  endtask

  task automatic sweep_zero(input string nm);
    int v, nz;
    nz = 0;
    for (int c = 0; c < DEPTH; c++) begin
      read_col(c, v);
      if (v != 0) nz++;
    end
    chk(nm, nz, 0);
  endtask

  initial begin
    int n, v;
    system_status = 3'd1;
    do_reset();
    chk("rst_ready", int'(ready), 0);
    chk("rst_wp", int'(write_ptr), 0);
    chk("rst_full", int'(buffer_full), 0);
    chk("rst_out", int'(signal_out), 0);
    wait_ready(n);
    chk("clear_len", n, 1024);
    sweep_zero("init_zero");

    // Four samples average to one entry.
    feed(10); feed(11); feed(12); feed(13);
    chk("avg_wp", int'(write_ptr), 1);
    read_col(1023, v); chk("avg_newest", v, 11);
    read_col(0, v);    chk("avg_oldest", v, 0);

    // 1025 stored samples: fill, set full, wrap over entry 0.
    do_reset();
    wait_ready(n);
    for (int s = 0; s <= DEPTH; s++) begin
      for (int k = 0; k < NDEC; k++) feed(s % 256);
      if (s == DEPTH - 2) chk("full_early", int'(buffer_full), 0);
      if (s == DEPTH - 1) chk("full_at_1024", int'(buffer_full), 1);
    end
    chk("wrap_wp", int'(write_ptr), 1);
    read_col(0, v);    chk("wrap_col0", v, 1);
    read_col(1023, v); chk("wrap_col1023", v, 0);
    read_col(1022, v); chk("wrap_col1022", v, 255);

    // Partial accumulation dropped when leaving RUN.
    feed(100); feed(100);
    system_status = 3'd0;
    sample_in = 8'd200;
    sample_valid = 1'b1;
    repeat (5) tick();
    chk("hold_wp", int'(write_ptr), 1);
    sample_valid = 1'b0;
    system_status = 3'd1;
    tick();
    repeat (4) feed(40);
    chk("discard_wp", int'(write_ptr), 2);
    read_col(1023, v); chk("discard_val", v, 40);

    // Out-of-range column and read-first collision.
    signal_pix = 11'd1100;
    tick();
    chk("pix_oob", int'(signal_out), 0);
    signal_pix = 11'd0;
    feed(77); feed(77); feed(77); feed(77);
    chk("read_first", int'(signal_out), 2);
    read_col(1023, v); chk("collide_new", v, 77);
    read_col(0, v);    chk("collide_col0", v, 3);

    // Reset in RUN at write_ptr 500, mid-accumulation, then mid-clear.
    do_reset();
    wait_ready(n);
    for (int s = 0; s < 500 * NDEC; s++) feed(5);
    feed(9); feed(9);
    chk("pre_rst_wp", int'(write_ptr), 500);
    reset = 1'b1;
    tick();
    chk("mid_rst_wp", int'(write_ptr), 0);
    chk("mid_rst_full", int'(buffer_full), 0);
    chk("mid_rst_ready", int'(ready), 0);
    reset = 1'b0;
    repeat (300) tick();
    chk("midclear_ready", int'(ready), 0);
    do_reset();
    wait_ready(n);
    chk("reclear_len", n, 1024);
    sweep_zero("reclear_zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
